// File: rtl/hack_seq_pkg.sv
// Shared encodings for the Hack fetch/execute sequencer: FSM states and
// the instruction bit positions the sequencer decodes.
package hack_seq_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam int IS_C = 15;
  localparam int D3   = 3;
  localparam int J1   = 2;
  localparam int J2   = 1;
  localparam int J3   = 0;

endpackage

// File: rtl/hack_jump_eval.sv
// C-instruction jump condition from the j-bits and ALU flags; kept standalone
// so branch prediction can evaluate the same condition early.
module hack_jump_eval
  import hack_seq_pkg::*;
(
  input  logic [2:0] jbits,
  input  logic       zr,
  input  logic       ng,
  output logic       jump
);

  assign jump = (jbits[J1] & ng) | (jbits[J2] & zr) | (jbits[J3] & ~ng & ~zr);

endmodule

// File: rtl/hack_sequencer.sv
// Fetch/execute sequencer: drives PC controls, the imem handshake, the IR load
// and the single exec_en commit strobe; counts retired instructions.
module hack_sequencer
  import hack_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] instr,
  input  logic             zr,
  input  logic             ng,
  input  logic             mem_busy,
  input  logic             halt_req,
  output logic             imem_req,
  output logic             ir_load,
  output logic             exec_en,
  output logic             pc_reset,
  output logic             pc_load,
  output logic             pc_inc,
  output logic             halted,
  output logic [WIDTH-1:0] retired
);

  state_t           r_state;
  state_t           w_next;
  logic             r_is_c;
  logic [3:0]       r_ir_lo;
  logic [WIDTH-1:0] r_retired;
  logic             w_jump;
  logic             w_unused;

  // Only the type bit and d3/j-bits matter here; the datapath IR keeps the rest.
  assign w_unused = ^instr;

  hack_jump_eval u_jump (
    .jbits (r_ir_lo[J1:J3]),
    .zr    (zr),
    .ng    (ng),
    .jump  (w_jump)
  );

  always_comb begin
    w_next   = r_state;
    imem_req = 1'b0;
    ir_load  = 1'b0;
    exec_en  = 1'b0;
    pc_reset = 1'b0;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    halted   = 1'b0;
    case (r_state)
      S_RESET: begin
        pc_reset = 1'b1;
        w_next   = S_FETCH;
      end
      S_FETCH: begin
        if (halt_req) begin
          w_next = S_HALT;
        end else begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_load = 1'b1;
            w_next  = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        // A data-memory write that cannot be accepted holds the whole commit.
        if (!r_is_c) begin
          exec_en = 1'b1;
          pc_inc  = 1'b1;
          w_next  = S_FETCH;
        end else if (!(r_ir_lo[D3] && mem_busy)) begin
          exec_en = 1'b1;
          pc_load = w_jump;
          pc_inc  = ~w_jump;
          w_next  = S_FETCH;
        end
      end
      S_HALT: begin
        halted = 1'b1;
        if (!halt_req) w_next = S_FETCH;
      end
      default: w_next = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_RESET;
      r_is_c    <= 1'b0;
      r_ir_lo   <= 4'd0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (ir_load) begin
        r_is_c  <= instr[IS_C];
        r_ir_lo <= instr[3:0];
      end
      if (exec_en) r_retired <= r_retired + 1'b1;
    end
  end

  assign retired = r_retired;

endmodule
